adder_pipe_param: RTL and testbench

ADDER_PIPE_PARAM -- requirements
Module: adder_pipe_param

---
 rtl/adder_pipe_param_if.sv | 55 +++++
 rtl/adder_pipe_param.sv | 127 ++++++++++++
 tb/tb_adder_pipe_param.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_param_if.sv
// ---------------------------------------------------------------------------
// adder_pipe_param_if
// Groups the operand/result handshake of the pipelined adder into a single
// bundle so the adder and its environment connect through one port.
//
//   i_en     upstream operand valid                 (master -> slave)
//   o_ready  adder can accept an operand this cycle (slave  -> master)
//   adda     operand A                              (master -> slave)
//   addb     operand B                              (master -> slave)
//   i_sub    0 = A+B, 1 = A-B, travels with operand (master -> slave)
//   i_ready  downstream can accept the result       (master -> slave)
//   o_en     result valid                           (slave  -> master)
//   result   {carry/borrow, sum/difference}         (slave  -> master)
//   o_ovf    signed overflow of the operation       (slave  -> master)
//
// The slave modport is the adder's view; the master modport is the view of
// whatever drives operands and consumes results.
// ---------------------------------------------------------------------------
interface adder_pipe_param_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  i_en;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] adda;
    logic [DATA_WIDTH-1:0] addb;
    logic                  i_sub;
    logic                  i_ready;
    logic                  o_en;
    logic [DATA_WIDTH:0]   result;
    logic                  o_ovf;

    modport slave (
        input  i_en,
        input  adda,
        input  addb,
        input  i_sub,
        input  i_ready,
        output o_ready,
        output o_en,
        output result,
        output o_ovf
    );

    modport master (
        output i_en,
        output adda,
        output addb,
        output i_sub,
        output i_ready,
        input  o_ready,
        input  o_en,
        input  result,
        input  o_ovf
    );
endinterface

// File: rtl/adder_pipe_param.sv
// ---------------------------------------------------------------------------
// adder_pipe_param
// Pipelined add/subtract unit. The DATA_WIDTH operands are split into
// NUM_STG = DATA_WIDTH/STG_WIDTH slices; stage k adds slice k together with
// the carry produced by stage k-1 for the same operand. Valid, mode, carry,
// operands and already-finished sum slices all ride along with the operand,
// so one new operand can enter every cycle and results leave in order.
//
// Ports
//   clk     single clock, all state updates on the rising edge
//   rst_n   asynchronous active-low reset, empties the pipeline
//   io_bus  operand/result handshake (adder_pipe_param_if.slave)
//
// Handshake: a stall exists when the last stage holds a valid result that
// downstream refuses. During a stall every stage holds and o_ready is low;
// otherwise every stage (valid or bubble) advances by one.
// Subtraction is performed as A + ~B + 1, so the top result bit is the
// inverted carry (borrow) in that mode.
// ---------------------------------------------------------------------------
module adder_pipe_param #(
    parameter int DATA_WIDTH = 64,
    parameter int STG_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_pipe_param_if.slave io_bus
);

    localparam int NUM_STG  = (STG_WIDTH > 0) ? (DATA_WIDTH / STG_WIDTH) : 0;
    localparam int LAST_STG = (NUM_STG > 0) ? (NUM_STG - 1) : 0;

    // Refuse to build a pipeline whose slices do not tile the operand.
    if ((STG_WIDTH < 1) || (NUM_STG < 1) ||
        (((STG_WIDTH > 0) ? (DATA_WIDTH % STG_WIDTH) : 1) != 0)) begin : g_bad_params
        $error("adder_pipe_param: DATA_WIDTH must be a non-zero multiple of STG_WIDTH");
    end

    // Per-stage state carried along with each operand
    logic                  r_valid [NUM_STG];
    logic                  r_sub   [NUM_STG];
    logic                  r_carry [NUM_STG];
    logic [DATA_WIDTH-1:0] r_opA   [NUM_STG];
    logic [DATA_WIDTH-1:0] r_opB   [NUM_STG];
    logic [DATA_WIDTH-1:0] r_sum   [NUM_STG];

    // What each stage sees at its input: the bus for stage 0, the previous
    // stage's registers for every later stage
    logic                  w_srcValid [NUM_STG];
    logic                  w_srcSub   [NUM_STG];
    logic                  w_srcCarry [NUM_STG];
    logic [DATA_WIDTH-1:0] w_srcA     [NUM_STG];
    logic [DATA_WIDTH-1:0] w_srcB     [NUM_STG];
    logic [DATA_WIDTH-1:0] w_srcSum   [NUM_STG];

    logic [STG_WIDTH:0]    w_stgAdd   [NUM_STG];
    logic [DATA_WIDTH-1:0] w_nxtSum   [NUM_STG];
    logic                  w_stall;

    // Stage 0 already holds the effective B (inverted for subtraction) and
    // the subtract carry-in, so the later stages never need to look at mode.
    for (genvar g = 0; g < NUM_STG; g++) begin : g_src
        if (g == 0) begin : g_first
            assign w_srcValid[g] = io_bus.i_en;
            assign w_srcSub[g]   = io_bus.i_sub;
            assign w_srcCarry[g] = io_bus.i_sub;
            assign w_srcA[g]     = io_bus.adda;
            assign w_srcB[g]     = io_bus.i_sub ? ~io_bus.addb : io_bus.addb;
            assign w_srcSum[g]   = '0;
        end else begin : g_next
            assign w_srcValid[g] = r_valid[g-1];
            assign w_srcSub[g]   = r_sub[g-1];
            assign w_srcCarry[g] = r_carry[g-1];
            assign w_srcA[g]     = r_opA[g-1];
            assign w_srcB[g]     = r_opB[g-1];
            assign w_srcSum[g]   = r_sum[g-1];
        end
    end

    // Each stage adds its own slice plus the incoming carry and splices the
    // new slice into the partial sum it inherited from upstream.
    always_comb begin
        for (int k = 0; k < NUM_STG; k++) begin
            w_stgAdd[k] = {1'b0, w_srcA[k][k*STG_WIDTH +: STG_WIDTH]}
                        + {1'b0, w_srcB[k][k*STG_WIDTH +: STG_WIDTH]}
                        + {{STG_WIDTH{1'b0}}, w_srcCarry[k]};
            w_nxtSum[k] = w_srcSum[k];
            w_nxtSum[k][k*STG_WIDTH +: STG_WIDTH] = w_stgAdd[k][STG_WIDTH-1:0];
        end
    end

    // Pipeline registers: cleared by reset, frozen during a stall, otherwise
    // every stage takes the content of the stage before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STG; k++) begin
                r_valid[k] <= 1'b0;
                r_sub[k]   <= 1'b0;
                r_carry[k] <= 1'b0;
                r_opA[k]   <= '0;
                r_opB[k]   <= '0;
                r_sum[k]   <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < NUM_STG; k++) begin
                r_valid[k] <= w_srcValid[k];
                r_sub[k]   <= w_srcSub[k];
                r_carry[k] <= w_stgAdd[k][STG_WIDTH];
                r_opA[k]   <= w_srcA[k];
                r_opB[k]   <= w_srcB[k];
                r_sum[k]   <= w_nxtSum[k];
            end
        end
    end

    assign w_stall        = r_valid[LAST_STG] && !io_bus.i_ready;
    assign io_bus.o_ready = !w_stall;
    assign io_bus.o_en    = r_valid[LAST_STG];

    // Borrow is the inverted carry when subtracting.
    assign io_bus.result  = {r_carry[LAST_STG] ^ r_sub[LAST_STG], r_sum[LAST_STG]};

    // r_opB already holds the effective B, so overflow is the classic
    // "same input signs, different result sign" test.
    assign io_bus.o_ovf   = (r_opA[LAST_STG][DATA_WIDTH-1] == r_opB[LAST_STG][DATA_WIDTH-1]) &&
                            (r_sum[LAST_STG][DATA_WIDTH-1] != r_opA[LAST_STG][DATA_WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe_param.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe_param
// Drives three adder configurations (64/16, 32/8 and 16/16) one at a time.
// Expected results come from a whole-word arithmetic model and are queued
// when an operand is accepted, then popped when a result is accepted.
// ---------------------------------------------------------------------------
module tb_adder_pipe_param;

    logic clk;
    logic rst_n;

    int nVectors;
    int nMiscompares;

    adder_pipe_param_if #(.DATA_WIDTH(64)) if64 ();
    adder_pipe_param_if #(.DATA_WIDTH(32)) if32 ();
    adder_pipe_param_if #(.DATA_WIDTH(16)) if16 ();

    adder_pipe_param #(.DATA_WIDTH(64), .STG_WIDTH(16)) u_dut64 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (if64.slave)
    );

    adder_pipe_param #(.DATA_WIDTH(32), .STG_WIDTH(8)) u_dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (if32.slave)
    );

    adder_pipe_param #(.DATA_WIDTH(16), .STG_WIDTH(16)) u_dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (if16.slave)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int widthOf(input int idx);
        return (idx == 0) ? 64 : ((idx == 1) ? 32 : 16);
    endfunction

    function automatic int stagesOf(input int idx);
        return (idx == 0) ? 4 : ((idx == 1) ? 4 : 1);
    endfunction

    // Whole-word reference: returns {ovf, result} for a w-bit adder
    function automatic logic [65:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bb;
        logic [64:0] full;
        logic [64:0] res;
        logic        cout;
        logic        ovf;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, b} & mask;
        if (s) bb = ~bb & mask;
        full = aa + bb + {64'd0, s};
        cout = full[w];
        res  = full & mask;
        res[w] = s ? ~cout : cout;
        ovf  = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
        return {ovf, res};
    endfunction

    // Drive the operand side of one configuration
    task automatic applyStimulus(input int idx, input logic en, input logic [63:0] a,
                                 input logic [63:0] b, input logic s);
        case (idx)
            0: begin if64.i_en = en; if64.adda = a;        if64.addb = b;        if64.i_sub = s; end
            1: begin if32.i_en = en; if32.adda = a[31:0];  if32.addb = b[31:0];  if32.i_sub = s; end
            default: begin if16.i_en = en; if16.adda = a[15:0]; if16.addb = b[15:0]; if16.i_sub = s; end
        endcase
    endtask

    task automatic setReady(input int idx, input logic r);
        case (idx)
            0: if64.i_ready = r;
            1: if32.i_ready = r;
            default: if16.i_ready = r;
        endcase
    endtask

    task automatic getOut(input int idx, output logic oen, output logic ordy,
                          output logic [64:0] res, output logic ovf);
        case (idx)
            0: begin oen = if64.o_en; ordy = if64.o_ready; res = if64.result;        ovf = if64.o_ovf; end
            1: begin oen = if32.o_en; ordy = if32.o_ready; res = 65'(if32.result);   ovf = if32.o_ovf; end
            default: begin oen = if16.o_en; ordy = if16.o_ready; res = 65'(if16.result); ovf = if16.o_ovf; end
        endcase
    endtask

    // Reset state of every configuration, checked while rst_n is low
    task automatic test_reset();
        logic oen, ordy, ovf;
        logic [64:0] res;
        for (int idx = 0; idx < 3; idx++) begin
            getOut(idx, oen, ordy, res, ovf);
            nVectors++;
            if (oen !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_o_en dut%0d: got %b expected 0", idx, oen);
            end
            nVectors++;
            if (res !== 65'd0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_result dut%0d: got %h expected 0", idx, res);
            end
            nVectors++;
            if (ovf !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_o_ovf dut%0d: got %b expected 0", idx, ovf);
            end
            nVectors++;
            if (ordy !== 1'b1) begin
                nMiscompares++;
                $display("[TB] FAIL reset_o_ready dut%0d: got %b expected 1", idx, ordy);
            end
        end
    endtask

    // Carry-out, borrow and overflow corners with an exact latency check
    task automatic test_corners(input int idx);
        int w, nstg, lat;
        logic [64:0] mask;
        logic [63:0] va [4];
        logic [63:0] vb [4];
        logic        vs [4];
        logic [64:0] er [4];
        logic        eo [4];
        logic oen, ordy, ovf;
        logic [64:0] res;
        w    = widthOf(idx);
        nstg = stagesOf(idx);
        mask = (65'd1 << w) - 65'd1;
        va[0] = mask[63:0];       vb[0] = 64'd1;      vs[0] = 1'b0;
        er[0] = 65'd1 << w;                            eo[0] = 1'b0;
        va[1] = 64'd0;            vb[1] = 64'd1;      vs[1] = 1'b1;
        er[1] = (65'd1 << (w + 1)) - 65'd1;            eo[1] = 1'b0;
        va[2] = mask[63:0] >> 1;  vb[2] = mask[63:0]; vs[2] = 1'b1;
        er[2] = (65'd1 << w) | (65'd1 << (w - 1));     eo[2] = 1'b1;
        va[3] = mask[63:0] >> 1;  vb[3] = 64'd1;      vs[3] = 1'b0;
        er[3] = 65'd1 << (w - 1);                      eo[3] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            setReady(idx, 1'b1);
            applyStimulus(idx, 1'b1, va[v], vb[v], vs[v]);
            lat = 0;
            res = '0;
            ovf = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) applyStimulus(idx, 1'b0, 64'd0, 64'd0, 1'b0);
                #1;
                getOut(idx, oen, ordy, res, ovf);
                if (oen) begin
                    lat = k;
                    break;
                end
            end
            nVectors++;
            if (lat != nstg) begin
                nMiscompares++;
                $display("[TB] FAIL corner_latency dut%0d vec%0d: got %0d cycles expected %0d", idx, v, lat, nstg);
            end
            nVectors++;
            if (res !== er[v]) begin
                nMiscompares++;
                $display("[TB] FAIL corner_result dut%0d vec%0d: got %h expected %h", idx, v, res, er[v]);
            end
            nVectors++;
            if (ovf !== eo[v]) begin
                nMiscompares++;
                $display("[TB] FAIL corner_ovf dut%0d vec%0d: got %b expected %b", idx, v, ovf, eo[v]);
            end
        end
    endtask

    // Scoreboarded stream; randCtl=0 gives a back-to-back stream with
    // i_ready held high, randCtl=1 toggles i_en and i_ready randomly.
    task automatic test_stream(input int idx, input int n, input bit randCtl);
        logic [65:0] q [$];
        logic [65:0] exp;
        int w, sent, got, cyc, bound;
        bit prevStall;
        logic [64:0] prevRes;
        logic prevOvf;
        logic curEn, curRdy, s;
        logic [63:0] a, b;
        logic oen, ordy, ovf;
        logic [64:0] res;
        w = widthOf(idx);
        sent = 0; got = 0; cyc = 0; bound = n * 10 + 50;
        prevStall = 1'b0; prevRes = '0; prevOvf = 1'b0;
        s = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        while ((sent < n || got < sent) && cyc < bound) begin
            @(negedge clk);
            cyc++;
            curEn  = (sent < n) && (randCtl ? ($urandom_range(0, 2) != 0) : 1'b1);
            curRdy = randCtl ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(idx, curEn, a, b, s);
            setReady(idx, curRdy);
            #1;
            getOut(idx, oen, ordy, res, ovf);
            nVectors++;
            if (ordy !== !(oen && !curRdy)) begin
                nMiscompares++;
                $display("[TB] FAIL o_ready dut%0d cyc%0d: got %b expected %b", idx, cyc, ordy, !(oen && !curRdy));
            end
            if (prevStall) begin
                nVectors++;
                if (oen !== 1'b1 || res !== prevRes || ovf !== prevOvf) begin
                    nMiscompares++;
                    $display("[TB] FAIL stall_hold dut%0d cyc%0d: got en=%b %b/%h expected en=1 %b/%h",
                             idx, cyc, oen, ovf, res, prevOvf, prevRes);
                end
            end
            if (!randCtl && got > 0 && got < n) begin
                nVectors++;
                if (oen !== 1'b1) begin
                    nMiscompares++;
                    $display("[TB] FAIL bubble dut%0d after %0d results: got o_en=%b expected 1", idx, got, oen);
                end
            end
            if (oen && curRdy) begin
                nVectors++;
                if (q.size() == 0) begin
                    nMiscompares++;
                    $display("[TB] FAIL extra_result dut%0d: got %h expected no result", idx, res);
                end else begin
                    exp = q.pop_front();
                    got++;
                    if ({ovf, res} !== exp) begin
                        nMiscompares++;
                        $display("[TB] FAIL stream_result dut%0d item%0d: got %b/%h expected %b/%h",
                                 idx, got, ovf, res, exp[65], exp[64:0]);
                    end
                end
            end
            if (curEn && ordy) begin
                q.push_back(refModel(a, b, s, w));
                sent++;
                s = ~s;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            prevStall = oen && !curRdy;
            prevRes   = res;
            prevOvf   = ovf;
        end
        nVectors++;
        if (got != n || sent != n) begin
            nMiscompares++;
            $display("[TB] FAIL stream_count dut%0d: got %0d results of %0d sent expected %0d", idx, got, sent, n);
        end
        @(negedge clk);
        applyStimulus(idx, 1'b0, 64'd0, 64'd0, 1'b0);
        setReady(idx, 1'b1);
    endtask

    // Reset with three items in flight, then one fresh operand on the first
    // edge after release
    task automatic test_reset_flight(input int idx);
        logic oen, ordy, ovf;
        logic [64:0] res;
        logic [65:0] exp;
        logic [63:0] a, b;
        int lat;
        @(negedge clk);
        setReady(idx, 1'b1);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(idx, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, j[0]);
            @(negedge clk);
        end
        applyStimulus(idx, 1'b0, 64'd0, 64'd0, 1'b0);
        setReady(idx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        getOut(idx, oen, ordy, res, ovf);
        nVectors++;
        if (oen !== 1'b0 || res !== 65'd0 || ovf !== 1'b0 || ordy !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL flight_reset dut%0d: got en=%b rdy=%b ovf=%b res=%h expected en=0 rdy=1 ovf=0 res=0",
                     idx, oen, ordy, ovf, res);
        end
        @(negedge clk);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        exp = refModel(a, b, 1'b1, widthOf(idx));
        applyStimulus(idx, 1'b1, a, b, 1'b1);
        setReady(idx, 1'b1);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(idx, 1'b0, 64'd0, 64'd0, 1'b0);
            #1;
            getOut(idx, oen, ordy, res, ovf);
            if (oen) begin
                lat = k;
                break;
            end
        end
        nVectors++;
        if (lat != stagesOf(idx)) begin
            nMiscompares++;
            $display("[TB] FAIL flight_latency dut%0d: got %0d cycles expected %0d", idx, lat, stagesOf(idx));
        end
        nVectors++;
        if ({ovf, res} !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL flight_result dut%0d: got %b/%h expected %b/%h", idx, ovf, res, exp[65], exp[64:0]);
        end
    endtask

    // Test sequence
    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst_n        = 1'b1;
        for (int idx = 0; idx < 3; idx++) begin
            applyStimulus(idx, 1'b0, 64'd0, 64'd0, 1'b0);
            setReady(idx, 1'b1);
        end
        #1 rst_n = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int idx = 0; idx < 3; idx++) begin
            $display("[TB] configuration %0d: width %0d, %0d stage(s)", idx, widthOf(idx), stagesOf(idx));
            test_corners(idx);
            test_stream(idx, 100, 1'b0);
            test_stream(idx, 60, 1'b1);
            test_reset_flight(idx);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
